traffic_monitor: RTL and testbench



---
 rtl/traffic_monitor.sv | 146 ++++++++++++++
 tb/tb_traffic_monitor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_monitor.sv
// Passive observer of the traffic light controller output. It predicts the light/counter
// sequence, latches the first deviation as a sticky error with a cause code, and counts periods.
module traffic_monitor #(
    parameter int RED_COUNT    = 60,
    parameter int GREEN_COUNT  = 40,
    parameter int YELLOW_COUNT = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] light,
    input  logic [7:0] time_left,
    input  logic       clr,
    output logic       err,
    output logic [2:0] err_code,
    output logic       in_sync,
    output logic [7:0] period_cnt,
    output logic       p1,
    output logic       p2
);

    typedef enum logic [1:0] {
        TRACK  = 2'd0,
        HALT   = 2'd1,
        RESYNC = 2'd2
    } state_t;

    localparam logic [1:0] L_RED    = 2'd0;
    localparam logic [1:0] L_GREEN  = 2'd1;
    localparam logic [1:0] L_YELLOW = 2'd2;
    localparam logic [1:0] L_ILL    = 2'd3;

    localparam logic [7:0] RED_RLD    = RED_COUNT[7:0];
    localparam logic [7:0] GREEN_RLD  = GREEN_COUNT[7:0];
    localparam logic [7:0] YELLOW_RLD = YELLOW_COUNT[7:0];

    state_t     state, state_nxt;
    logic [1:0] pred_light, pred_light_nxt;
    logic [7:0] pred_cnt, pred_cnt_nxt;
    logic       err_nxt;
    logic [2:0] err_code_nxt;
    logic [7:0] period_cnt_nxt;
    logic [2:0] cause;
    logic [7:0] bound;
    logic [9:0] pred_step;
    logic [9:0] obs_step;

    function automatic logic [7:0] reload_of(input logic [1:0] l);
        case (l)
            L_RED:    reload_of = RED_RLD;
            L_GREEN:  reload_of = GREEN_RLD;
            L_YELLOW: reload_of = YELLOW_RLD;
            default:  reload_of = 8'd0;
        endcase
    endfunction

    // Returns {light, count} one cycle later; phases only advance at count zero.
    function automatic logic [9:0] step(input logic [1:0] l, input logic [7:0] c);
        if (c != 8'd0) begin
            step = {l, c - 8'd1};
        end else begin
            case (l)
                L_RED:    step = {L_GREEN, GREEN_RLD};
                L_GREEN:  step = {L_YELLOW, YELLOW_RLD};
                L_YELLOW: step = {L_RED, RED_RLD};
                default:  step = {l, c};
            endcase
        end
    endfunction

    assign bound     = reload_of(light);
    assign p1        = (light == L_ILL);
    assign p2        = (light != L_ILL) && (time_left > bound);
    assign pred_step = step(pred_light, pred_cnt);
    assign obs_step  = step(light, time_left);
    assign in_sync   = (state == TRACK);

    always_comb begin
        cause = 3'd0;
        if (p1) begin
            cause = 3'd1;
        end else if (p2) begin
            cause = 3'd2;
        end else if (light != pred_light) begin
            cause = 3'd3;
        end else if (time_left != pred_cnt) begin
            cause = 3'd4;
        end
    end

    always_comb begin
        state_nxt      = state;
        pred_light_nxt = pred_light;
        pred_cnt_nxt   = pred_cnt;
        err_nxt        = err;
        err_code_nxt   = err_code;
        period_cnt_nxt = period_cnt;
        // clr wins over anything detected on the same sample
        if (clr) begin
            err_nxt      = 1'b0;
            err_code_nxt = 3'd0;
            state_nxt    = RESYNC;
        end else begin
            case (state)
                TRACK: begin
                    if (cause != 3'd0) begin
                        err_nxt      = 1'b1;
                        err_code_nxt = cause;
                        state_nxt    = HALT;
                    end else begin
                        {pred_light_nxt, pred_cnt_nxt} = pred_step;
                        if (pred_light == L_YELLOW && pred_cnt == 8'd0) begin
                            period_cnt_nxt = period_cnt + 8'd1;
                        end
                    end
                end
                RESYNC: begin
                    if (light != L_ILL && !p2) begin
                        {pred_light_nxt, pred_cnt_nxt} = obs_step;
                        state_nxt = TRACK;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= TRACK;
            pred_light <= L_RED;
            pred_cnt   <= 8'd0;
            err        <= 1'b0;
            err_code   <= 3'd0;
            period_cnt <= 8'd0;
        end else begin
            state      <= state_nxt;
            pred_light <= pred_light_nxt;
            pred_cnt   <= pred_cnt_nxt;
            err        <= err_nxt;
            err_code   <= err_code_nxt;
            period_cnt <= period_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_traffic_monitor.sv
// Directed bench for traffic_monitor: a reference controller feeds the monitor, with
// selected samples overridden to provoke each error cause, clr resync and reset.
module tb_traffic_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] light;
    logic [7:0] time_left;
    logic       clr;
    logic       err;
    logic [2:0] err_code;
    logic       in_sync;
    logic [7:0] period_cnt;
    logic       p1;
    logic       p2;

    int vectors = 0;
    int miscompares = 0;
    int cl, cc;
    int seen_err;
    int found;

    traffic_monitor #(.RED_COUNT(60), .GREEN_COUNT(40), .YELLOW_COUNT(5)) dut (
        .clk(clk), .reset(reset), .light(light), .time_left(time_left), .clr(clr),
        .err(err), .err_code(err_code), .in_sync(in_sync), .period_cnt(period_cnt),
        .p1(p1), .p2(p2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic ctl_step();
        if (cc != 0) begin
            cc = cc - 1;
        end else begin
            case (cl)
                0: begin cl = 1; cc = 40; end
                1: begin cl = 2; cc = 5; end
                default: begin cl = 0; cc = 60; end
            endcase
        end
    endtask

    task automatic drive(input int l, input int t, input logic c);
        light = l[1:0];
        time_left = t[7:0];
        clr = c;
        #1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
        ctl_step();
        if (err) seen_err = 1;
    endtask

    task automatic apply(input int l, input int t, input logic c);
        drive(l, t, c);
        edge_step();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) apply(cl, cc, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clr = 1'b0;
        light = 2'd0;
        time_left = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cl = 0;
        cc = 0;
        seen_err = 0;
    endtask

    initial begin
        reset = 1'b0;
        clr = 1'b0;
        light = 2'd0;
        time_left = 8'd0;
        #1;
        check("reset_err", err, 0);
        check("reset_code", err_code, 0);
        check("reset_insync", in_sync, 1);
        check("reset_period", period_cnt, 0);

        // Clean run of 300 samples
        do_reset();
        for (int k = 0; k < 300; k++) begin
            apply(cl, cc, 1'b0);
            if (k == 46) check("period_c46", period_cnt, 0);
            if (k == 47) check("period_c47", period_cnt, 1);
            if (k == 155) check("period_c155", period_cnt, 2);
        end
        check("clean_err", seen_err, 0);
        check("clean_period", period_cnt, 3);
        check("clean_insync", in_sync, 1);

        // Illegal light code on cycle 10
        do_reset();
        run(10);
        drive(3, cc, 1'b0);
        check("ill_p1", p1, 1);
        edge_step();
        check("ill_err", err, 1);
        check("ill_code", err_code, 1);
        check("ill_insync", in_sync, 0);
        run(5);
        check("ill_code_held", err_code, 1);

        // Reload value legal at GREEN entry; reload+1 is cause 2
        do_reset();
        run(1);
        drive(cl, cc, 1'b0);
        check("grn40_p2", p2, 0);
        edge_step();
        check("grn40_err", err, 0);
        run(3);
        drive(cl, 41, 1'b0);
        check("grn41_p2", p2, 1);
        edge_step();
        check("grn41_code", err_code, 2);

        // Repeated count in RED is cause 4, then clr and resync
        do_reset();
        run(97);
        apply(cl, 12, 1'b0);
        check("cnt_code", err_code, 4);
        check("cnt_err", err, 1);
        apply(cl, cc, 1'b1);
        check("clr_err", err, 0);
        check("clr_insync", in_sync, 0);
        apply(cl, cc, 1'b0);
        check("resync_insync", in_sync, 1);
        seen_err = 0;
        run(200);
        check("resync_clean", seen_err, 0);

        // Wrong light with a consistent count is cause 3
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            if (cl == 0 && cc == 20) found = 1;
            else apply(cl, cc, 1'b0);
        end
        check("find_red20", found, 1);
        apply(1, cc, 1'b0);
        check("light_code", err_code, 3);

        // Asynchronous reset while halted
        #2;
        reset = 1'b0;
        #1;
        check("halt_rst_err", err, 0);
        check("halt_rst_code", err_code, 0);
        check("halt_rst_insync", in_sync, 1);
        check("halt_rst_period", period_cnt, 0);
        @(negedge clk);
        reset = 1'b1;
        cl = 0;
        cc = 0;
        seen_err = 0;
        run(20);
        check("post_rst_clean", seen_err, 0);
        check("post_rst_insync", in_sync, 1);

        // clr on the same sample as a mismatch discards it
        apply(3, cc, 1'b1);
        check("clrmis_err", err, 0);
        check("clrmis_insync", in_sync, 0);
        apply(3, cc, 1'b0);
        check("resync_ill_err", err, 0);
        check("resync_ill_insync", in_sync, 0);
        apply(cl, cc, 1'b0);
        check("resync2_insync", in_sync, 1);
        seen_err = 0;
        run(10);
        check("resync2_clean", seen_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
